// File: rtl/and2_share_arbiter.sv
// and2_share_arbiter
//   Round-robin arbiter and sequencer that shares one WIDTH-bit bitwise AND
//   unit among NREQ requesters. One operand pair is accepted per transaction.
//   The result, tagged with the requester id, is registered and held until
//   the consumer takes it.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid
//   req_ready  per-requester grant, combinational, at most one bit high, IDLE only
//   req_a      operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      operand b, same packing
//   rsp_valid  result valid
//   rsp_ready  consumer accepts result
//   rsp_id     requester that owns the result
//   rsp_data   registered a & b
//   busy       FSM not in IDLE
//   op_count   completed responses, saturating at 16'hFFFF
module and2_share_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 5,
    parameter int unsigned IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEval = 2'd1,
        StHold = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               gnt_found;
    logic [IDW-1:0]     gnt_idx;
    logic [WIDTH-1:0]   gnt_a;
    logic [WIDTH-1:0]   gnt_b;

    // Search upward starting one past the last grant; the first hit wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_a     = '0;
        gnt_b     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            int unsigned idx;
            idx = (32'(ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
                gnt_a     = req_a[idx*WIDTH +: WIDTH];
                gnt_b     = req_b[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    a_d     = gnt_a;
                    b_d     = gnt_b;
                    id_d    = gnt_idx;
                    ptr_d   = gnt_idx;
                    state_d = StEval;
                end
            end
            StEval: begin
                rsp_data_d  = a_q & b_q;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign op_count  = cnt_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_and2_share_arbiter.sv
// Directed testbench for and2_share_arbiter (NREQ=4, WIDTH=5, IDW=2).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_and2_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [19:0] req_a;
    logic [19:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [4:0]  rsp_data;
    logic        busy;
    logic [15:0] op_count;

    int checks;
    int errors;

    // Hand-computed a & b for the shared operand set loaded by load_ops.
    logic [4:0] exp_d [4];

    and2_share_arbiter #(
        .NREQ (4),
        .WIDTH(5),
        .IDW  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .busy     (busy),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge through one rising edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic load_ops;
        req_a = {5'b11111, 5'b10101, 5'b01110, 5'b11001};
        req_b = {5'b00111, 5'b11011, 5'b11010, 5'b10011};
    endtask

    task automatic test_reset;
        do_reset;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
        end
        checks++;
        if (rsp_id !== 2'd0) begin
            errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id);
        end
        checks++;
        if (rsp_data !== 5'd0) begin
            errors++; $display("FAIL reset_rsp_data got %b want 00000", rsp_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (op_count !== 16'd0) begin
            errors++; $display("FAIL reset_op_count got %0d want 0", op_count);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready);
        end
    endtask

    task automatic test_single;
        req_a       = '0;
        req_b       = '0;
        req_a[4:0]  = 5'b10110;
        req_b[4:0]  = 5'b11100;
        req_valid   = 4'b0001;
        rsp_ready   = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_grant got %b want 0001", req_ready);
        end
        tick;
        req_valid = 4'b0000;
        #1;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_eval busy=%b rsp_valid=%b req_ready=%b want 1 0 0000",
                     busy, rsp_valid, req_ready);
        end
        tick;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 5'b10100 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL single_rsp valid=%b data=%b id=%0d want 1 10100 0",
                     rsp_valid, rsp_data, rsp_id);
        end
        tick;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || op_count !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done valid=%b count=%0d busy=%b want 0 1 0",
                     rsp_valid, op_count, busy);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_rdy;
        do_reset;
        load_ops;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int e;
            e = i % 4;
            exp_rdy    = 4'b0000;
            exp_rdy[e] = 1'b1;
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL rr_grant%0d got %b want %b", i, req_ready, exp_rdy);
            end
            tick;
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL rr_eval_ready%0d got %b want 0000", i, req_ready);
            end
            tick;
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(e) || rsp_data !== exp_d[e]) begin
                errors++;
                $display("FAIL rr_rsp%0d valid=%b id=%0d data=%b want 1 %0d %b",
                         i, rsp_valid, rsp_id, rsp_data, e, exp_d[e]);
            end
            tick;
        end
        #1;
        checks++;
        if (op_count !== 16'd6) begin
            errors++; $display("FAIL rr_count got %0d want 6", op_count);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_wrap;
        int seq [4];
        logic [3:0] exp_rdy;
        seq = '{3, 0, 2, 0};
        do_reset;
        load_ops;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid  = (i == 0) ? 4'b1000 : 4'b0101;
            exp_rdy    = 4'b0000;
            exp_rdy[seq[i]] = 1'b1;
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL wrap_grant%0d got %b want %b", i, req_ready, exp_rdy);
            end
            tick;
            tick;
            #1;
            checks++;
            if (rsp_id !== 2'(seq[i]) || rsp_data !== exp_d[seq[i]]) begin
                errors++;
                $display("FAIL wrap_rsp%0d id=%0d data=%b want %0d %b",
                         i, rsp_id, rsp_data, seq[i], exp_d[seq[i]]);
            end
            tick;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_backpressure;
        do_reset;
        load_ops;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_grant got %b want 0010", req_ready);
        end
        tick;
        tick;
        for (int i = 0; i < 5; i++) begin
            req_a[9:5] = 5'(i * 7 + 3);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 5'b01010 || rsp_id !== 2'd1 ||
                req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d valid=%b data=%b id=%0d ready=%b busy=%b want 1 01010 1 0000 1",
                         i, rsp_valid, rsp_data, rsp_id, req_ready, busy);
            end
            tick;
        end
        load_ops;
        rsp_ready = 1'b1;
        tick;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0010 || op_count !== 16'd1) begin
            errors++;
            $display("FAIL bp_release valid=%b ready=%b count=%0d want 0 0010 1",
                     rsp_valid, req_ready, op_count);
        end
        req_valid = 4'b0000;
        tick;
        tick;
        tick;
    endtask

    task automatic test_reset_mid;
        do_reset;
        load_ops;
        rsp_ready = 1'b1;
        // Grant requester 2 so a stale pointer would favour requester 3.
        req_valid = 4'b0100;
        tick;
        req_valid = 4'b1111;
        rst       = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_eval valid=%b busy=%b count=%0d want 0 0 0",
                     rsp_valid, busy, op_count);
        end
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rst_eval_grant got %b want 0001", req_ready);
        end
        // Take requester 0, then reset in HOLD with rsp_ready high.
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_hold valid=%b busy=%b count=%0d want 0 0 0",
                     rsp_valid, busy, op_count);
        end
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rst_hold_grant got %b want 0001", req_ready);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_saturation;
        do_reset;
        load_ops;
        rsp_ready = 1'b1;
        force dut.cnt_q = 16'hFFFE;
        tick;
        release dut.cnt_q;
        #1;
        checks++;
        if (op_count !== 16'hFFFE) begin
            errors++; $display("FAIL sat_preload got %h want fffe", op_count);
        end
        req_valid = 4'b0001;
        tick;
        tick;
        tick;
        #1;
        checks++;
        if (op_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_reach got %h want ffff", op_count);
        end
        tick;
        tick;
        tick;
        #1;
        checks++;
        if (op_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold got %h want ffff", op_count);
        end
        req_valid = 4'b0000;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_d[0]  = 5'b10001;
        exp_d[1]  = 5'b01010;
        exp_d[2]  = 5'b10001;
        exp_d[3]  = 5'b00111;
        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        @(negedge clk);
        test_reset;
        test_single;
        test_round_robin;
        test_wrap;
        test_backpressure;
        test_reset_mid;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
